// File: rtl/sramlike_arbiter.sv
// sramlike_arbiter
// ----------------
// N-to-1 arbiter for the sram-like bus. It grants one upstream master per
// address phase. Accepted-but-unanswered transactions are recorded in an
// in-order ID FIFO, so each returning data_ok/rdata is steered back to the
// master that issued the request. Handshakes pass straight through
// combinationally, so the arbiter adds no latency.
//
// Optional build macro:
//   SRARB_RR_EN  - round-robin arbitration. When it is undefined, the lowest
//                  requesting index wins (fixed priority).
//
// Ports:
//   clk, rst        clock; asynchronous active-low reset
//   m_req/m_wr      per-master request / write flag           [NCH]
//   m_size          per-master size, 2 bits each              [2*NCH]
//   m_addr/m_wdata  per-master address / write data, packed   [AW*NCH]/[DW*NCH]
//   m_addr_ok       address accepted (one-hot or zero)
//   m_data_ok       response returned (one-hot or zero)
//   m_rdata         shared read data
//   s_req..s_wdata  downstream request fields
//   s_addr_ok/s_data_ok/s_rdata  downstream handshakes and read data
//   outstanding     current ID FIFO occupancy
//   err_spurious    sticky: s_data_ok arrived while nothing was outstanding
module sramlike_arbiter #(
    parameter int NCH   = 2,
    parameter int AW    = 32,
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NCH-1:0]           m_req,
    input  logic [NCH-1:0]           m_wr,
    input  logic [2*NCH-1:0]         m_size,
    input  logic [AW*NCH-1:0]        m_addr,
    input  logic [DW*NCH-1:0]        m_wdata,
    output logic [NCH-1:0]           m_addr_ok,
    output logic [NCH-1:0]           m_data_ok,
    output logic [DW-1:0]            m_rdata,
    output logic                     s_req,
    output logic                     s_wr,
    output logic [1:0]               s_size,
    output logic [AW-1:0]            s_addr,
    output logic [DW-1:0]            s_wdata,
    input  logic                     s_addr_ok,
    input  logic                     s_data_ok,
    input  logic [DW-1:0]            s_rdata,
    output logic [$clog2(DEPTH):0]   outstanding,
    output logic                     err_spurious
);

    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int PW  = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    typedef logic [IDW-1:0] id_t;

    logic          lock_v;
    id_t           lock_id;
    id_t           win;
    id_t           g;
    id_t           head;
    id_t           fifo_q [DEPTH];
    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [PW:0]   count;
    logic          full;
    logic          empty;
    logic          accept;
    logic          pop;

`ifdef SRARB_RR_EN
    id_t rr_ptr;

    // Scan cyclically, starting at rr_ptr; the first requester found wins.
    always_comb begin
        logic found;
        int   idx;
        win   = '0;
        found = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NCH) idx = idx - NCH;
            if (!found && m_req[idx]) begin
                win   = id_t'(idx);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr <= '0;
        end else if (accept) begin
            rr_ptr <= (g == id_t'(NCH-1)) ? '0 : id_t'(g + 1'b1);
        end
    end
`else
    // Fixed priority: the downward scan leaves the lowest requesting index.
    always_comb begin
        win = '0;
        for (int i = NCH-1; i >= 0; i--) begin
            if (m_req[i]) win = id_t'(i);
        end
    end
`endif

    // A stalled request keeps its grant until it is accepted, so that the
    // downstream sees stable request fields.
    assign g     = lock_v ? lock_id : win;
    assign head  = fifo_q[rptr];
    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);

    // Gating with rst forces every handshake low while reset is held.
    assign s_req  = rst & m_req[g] & ~full;
    assign accept = s_req & s_addr_ok;
    assign pop    = rst & s_data_ok & ~empty;

    assign s_wr    = m_wr[g];
    assign s_size  = m_size[int'(g)*2 +: 2];
    assign s_addr  = m_addr[int'(g)*AW +: AW];
    assign s_wdata = m_wdata[int'(g)*DW +: DW];
    assign m_rdata = s_rdata;

    always_comb begin
        m_addr_ok = '0;
        m_data_ok = '0;
        if (accept) m_addr_ok[g]    = 1'b1;
        if (pop)    m_data_ok[head] = 1'b1;
    end

    assign outstanding = count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lock_v       <= 1'b0;
            lock_id      <= '0;
            wptr         <= '0;
            rptr         <= '0;
            count        <= '0;
            err_spurious <= 1'b0;
        end else begin
            if (accept) begin
                lock_v <= 1'b0;
            end else if (s_req) begin
                lock_v  <= 1'b1;
                lock_id <= g;
            end
            if (accept) wptr <= wptr + 1'b1;
            if (pop)    rptr <= rptr + 1'b1;
            case ({accept, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (s_data_ok && empty) err_spurious <= 1'b1;
        end
    end

    // The ID storage has no reset; pointers and occupancy decide validity.
    always_ff @(posedge clk) begin
        if (accept) fifo_q[wptr] <= g;
    end

endmodule

// File: tb/tb_sramlike_arbiter.sv
module tb_sramlike_arbiter;

    localparam int NCH   = 2;
    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 2;
    localparam int NV    = 29;

`ifdef SRARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    localparam logic [31:0] A0 = 32'h0000_1000;
    localparam logic [31:0] A1 = 32'h0000_2000;
    localparam logic [31:0] W0 = 32'hAAAA_0000;
    localparam logic [31:0] W1 = 32'hBBBB_1111;

    logic               clk;
    logic               rst;
    logic [NCH-1:0]     m_req;
    logic [NCH-1:0]     m_wr;
    logic [2*NCH-1:0]   m_size;
    logic [AW*NCH-1:0]  m_addr;
    logic [DW*NCH-1:0]  m_wdata;
    logic [NCH-1:0]     m_addr_ok;
    logic [NCH-1:0]     m_data_ok;
    logic [DW-1:0]      m_rdata;
    logic               s_req;
    logic               s_wr;
    logic [1:0]         s_size;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_wdata;
    logic               s_addr_ok;
    logic               s_data_ok;
    logic [DW-1:0]      s_rdata;
    logic [$clog2(DEPTH):0] outstanding;
    logic               err_spurious;

    int n_cmp  = 0;
    int n_fail = 0;

    sramlike_arbiter #(.NCH(NCH), .AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
        .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
        .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
        .outstanding(outstanding), .err_spurious(err_spurious)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [1:0]  req;
        logic        sao;
        logic        sdo;
        logic [31:0] rdata;
        logic        e_sreq;
        logic [31:0] e_addr;
        logic [1:0]  e_mao;
        logic [1:0]  e_mdo;
        logic [1:0]  e_out;
        logic        e_err;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [1:0] rq, input logic sa,
                                input logic sd, input logic [31:0] rd, input logic es,
                                input logic [31:0] ea, input logic [1:0] ema,
                                input logic [1:0] emd, input logic [1:0] eo, input logic ee);
        vec_t v;
        v.rst = r; v.req = rq; v.sao = sa; v.sdo = sd; v.rdata = rd;
        v.e_sreq = es; v.e_addr = ea; v.e_mao = ema; v.e_mdo = emd;
        v.e_out = eo; v.e_err = ee;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        logic [1:0] prev_g;
        logic [1:0] gexp;

        rst       = 1'b0;
        m_req     = '0;
        m_wr      = 2'b01;
        m_size    = {2'd1, 2'd2};
        m_addr    = {A1, A0};
        m_wdata   = {W1, W0};
        s_addr_ok = 1'b0;
        s_data_ok = 1'b0;
        s_rdata   = '0;

        //            rst req    sao sdo rdata          sreq addr mao    mdo    out err
        vecs[0]  = mk(0, 2'b11, 1, 1, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        // single read from ch1, response three cycles after acceptance
        vecs[1]  = mk(1, 2'b10, 1, 0, 32'h0,         1, A1, 2'b10, 2'b00, 2'd0, 0);
        vecs[2]  = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd1, 0);
        vecs[3]  = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd1, 0);
        vecs[4]  = mk(1, 2'b00, 0, 1, 32'hDEADBEEF,  0, A0, 2'b00, 2'b10, 2'd1, 0);
        vecs[5]  = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        // ch1 stalled four cycles, ch0 joins: ch1 stays granted
        vecs[6]  = mk(1, 2'b10, 0, 0, 32'h0,         1, A1, 2'b00, 2'b00, 2'd0, 0);
        vecs[7]  = mk(1, 2'b11, 0, 0, 32'h0,         1, A1, 2'b00, 2'b00, 2'd0, 0);
        vecs[8]  = mk(1, 2'b11, 0, 0, 32'h0,         1, A1, 2'b00, 2'b00, 2'd0, 0);
        vecs[9]  = mk(1, 2'b11, 0, 0, 32'h0,         1, A1, 2'b00, 2'b00, 2'd0, 0);
        vecs[10] = mk(1, 2'b11, 1, 0, 32'h0,         1, A1, 2'b10, 2'b00, 2'd0, 0);
        vecs[11] = mk(1, 2'b01, 1, 0, 32'h0,         1, A0, 2'b01, 2'b00, 2'd1, 0);
        // full: third request blocked, pop does not unblock in the same cycle
        vecs[12] = mk(1, 2'b01, 1, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd2, 0);
        vecs[13] = mk(1, 2'b01, 1, 1, 32'h11111111,  0, A0, 2'b00, 2'b10, 2'd2, 0);
        vecs[14] = mk(1, 2'b01, 1, 0, 32'h0,         1, A0, 2'b01, 2'b00, 2'd1, 0);
        vecs[15] = mk(1, 2'b00, 0, 1, 32'h22222222,  0, A0, 2'b00, 2'b01, 2'd2, 0);
        vecs[16] = mk(1, 2'b00, 0, 1, 32'h33333333,  0, A0, 2'b00, 2'b01, 2'd1, 0);
        // interleaved ch0/ch1/ch0 with a simultaneous push and pop
        vecs[17] = mk(1, 2'b01, 1, 0, 32'h0,         1, A0, 2'b01, 2'b00, 2'd0, 0);
        vecs[18] = mk(1, 2'b10, 1, 0, 32'h0,         1, A1, 2'b10, 2'b00, 2'd1, 0);
        vecs[19] = mk(1, 2'b00, 0, 1, 32'h44444444,  0, A0, 2'b00, 2'b01, 2'd2, 0);
        vecs[20] = mk(1, 2'b01, 1, 1, 32'h55555555,  1, A0, 2'b01, 2'b10, 2'd1, 0);
        vecs[21] = mk(1, 2'b00, 0, 1, 32'h66666666,  0, A0, 2'b00, 2'b01, 2'd1, 0);
        vecs[22] = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        // spurious response, then reset during an outstanding transaction
        vecs[23] = mk(1, 2'b00, 0, 1, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        vecs[24] = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 1);
        vecs[25] = mk(1, 2'b01, 1, 0, 32'h0,         1, A0, 2'b01, 2'b00, 2'd0, 1);
        vecs[26] = mk(0, 2'b11, 1, 1, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        vecs[27] = mk(1, 2'b00, 0, 1, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 0);
        vecs[28] = mk(1, 2'b00, 0, 0, 32'h0,         0, A0, 2'b00, 2'b00, 2'd0, 1);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            rst       = vecs[i].rst;
            m_req     = vecs[i].req;
            s_addr_ok = vecs[i].sao;
            s_data_ok = vecs[i].sdo;
            s_rdata   = vecs[i].rdata;
            #1;
            check($sformatf("v%0d s_req", i), 32'(s_req), 32'(vecs[i].e_sreq));
            if (vecs[i].e_sreq)
                check($sformatf("v%0d s_addr", i), s_addr, vecs[i].e_addr);
            check($sformatf("v%0d m_addr_ok", i), 32'(m_addr_ok), 32'(vecs[i].e_mao));
            check($sformatf("v%0d m_data_ok", i), 32'(m_data_ok), 32'(vecs[i].e_mdo));
            if (vecs[i].e_mdo != 2'b00)
                check($sformatf("v%0d m_rdata", i), m_rdata, vecs[i].rdata);
            check($sformatf("v%0d outstanding", i), 32'(outstanding), 32'(vecs[i].e_out));
            check($sformatf("v%0d err_spurious", i), 32'(err_spurious), 32'(vecs[i].e_err));
        end

        // Both masters request every cycle with the downstream always ready.
        @(negedge clk);
        rst = 1'b0; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        #1;
        check("rst err_spurious", 32'(err_spurious), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        prev_g = 2'd0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            m_req     = 2'b11;
            s_addr_ok = 1'b1;
            s_data_ok = (k > 0);
            s_rdata   = 32'hC0DE_0000 + 32'(k);
            gexp      = RR ? 2'(k % 2) : 2'd0;
            #1;
            check($sformatf("arb%0d m_addr_ok", k), 32'(m_addr_ok), 32'(2'b01 << gexp));
            check($sformatf("arb%0d s_addr", k), s_addr, (gexp == 2'd0) ? A0 : A1);
            check($sformatf("arb%0d s_wdata", k), s_wdata, (gexp == 2'd0) ? W0 : W1);
            check($sformatf("arb%0d s_wr", k), 32'(s_wr), (gexp == 2'd0) ? 32'd1 : 32'd0);
            check($sformatf("arb%0d s_size", k), 32'(s_size), (gexp == 2'd0) ? 32'd2 : 32'd1);
            check($sformatf("arb%0d m_data_ok", k), 32'(m_data_ok),
                  (k == 0) ? 32'd0 : 32'(2'b01 << prev_g));
            check($sformatf("arb%0d outstanding", k), 32'(outstanding), (k == 0) ? 32'd0 : 32'd1);
            prev_g = gexp;
        end

        @(negedge clk);
        m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
